// File: rtl/pixel_mem_arbiter_if.sv
// Bundle of every arbitrated signal around the pixel frame RAM: two writers, VGA fetch, CPU read-back and the RAM ports.
// Pure wiring, no latency of its own.
// Requesters hold *_req until they see the matching *_gnt; VGA is never held off.
interface pixel_mem_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 32,
    parameter int QW = 8
);
    // Writer 0 (processor store path)
    logic          m0_wr_req;
    logic [AW-1:0] m0_wr_addr;
    logic [DW-1:0] m0_wr_data;
    logic          m0_wr_gnt;

    // Writer 1 (image loader)
    logic          m1_wr_req;
    logic [AW-1:0] m1_wr_addr;
    logic [DW-1:0] m1_wr_data;
    logic          m1_wr_gnt;

    // VGA scan-out fetch (absolute priority on the read port)
    logic          vga_rd_en;
    logic [AW-1:0] vga_rd_addr;

    // Processor read-back
    logic          cpu_rd_req;
    logic [AW-1:0] cpu_rd_addr;
    logic          cpu_rd_gnt;
    logic          cpu_rd_valid;
    logic [QW-1:0] cpu_rd_data;

    // Status
    logic          wr_oob_err;

    // RAM write and read ports
    logic          ram_wren;
    logic [AW-1:0] ram_wraddress;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_rdaddress;
    logic [QW-1:0] ram_q;

    // Arbiter side
    modport slave (
        input  m0_wr_req, m0_wr_addr, m0_wr_data,
        output m0_wr_gnt,
        input  m1_wr_req, m1_wr_addr, m1_wr_data,
        output m1_wr_gnt,
        input  vga_rd_en, vga_rd_addr,
        input  cpu_rd_req, cpu_rd_addr,
        output cpu_rd_gnt, cpu_rd_valid, cpu_rd_data,
        output wr_oob_err,
        output ram_wren, ram_wraddress, ram_data, ram_rdaddress,
        input  ram_q
    );

    // Everything surrounding the arbiter: requesters plus the RAM instance
    modport master (
        output m0_wr_req, m0_wr_addr, m0_wr_data,
        input  m0_wr_gnt,
        output m1_wr_req, m1_wr_addr, m1_wr_data,
        input  m1_wr_gnt,
        output vga_rd_en, vga_rd_addr,
        output cpu_rd_req, cpu_rd_addr,
        input  cpu_rd_gnt, cpu_rd_valid, cpu_rd_data,
        input  wr_oob_err,
        input  ram_wren, ram_wraddress, ram_data, ram_rdaddress,
        output ram_q
    );
endinterface

// File: rtl/pixel_mem_arbiter.sv
// Owns both pixel frame RAM ports: round-robin write port for m0/m1, VGA-first read port lending idle slots to the CPU.
// Write grant combinational, RAM write issued 1 cycle later; CPU read data valid RD_LAT+1 cycles after its grant.
// Writers/CPU stall by holding req until gnt; VGA is never stalled. Optional stall counters under PIXMEM_ARB_PERF_EN.
module pixel_mem_arbiter #(
    parameter int          AW     = 18,
    parameter int          DW     = 32,
    parameter int          QW     = 8,
    parameter int unsigned DEPTH  = 262144,
    parameter int          RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PIXMEM_ARB_PERF_EN
    input  logic        perf_clr,
    output logic [15:0] m0_stall_cnt,
    output logic [15:0] m1_stall_cnt,
    output logic [15:0] cpu_rd_stall_cnt,
`endif
    pixel_mem_arbiter_if.slave bus
);

    // DEPTH may equal 2**AW, so compare with one extra bit of headroom.
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Write port arbitration
    // ------------------------------------------------------------------
    logic          last_wr;       // index of the most recent write winner
    logic          gnt0;
    logic          gnt1;
    logic          wr_any;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_in_range;

    // Round-robin grant: a lone requester always wins, a tie goes to the one that did not win last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.m0_wr_req && bus.m1_wr_req) begin
                gnt0 = last_wr;
                gnt1 = ~last_wr;
            end else begin
                gnt0 = bus.m0_wr_req;
                gnt1 = bus.m1_wr_req;
            end
        end
    end

    assign wr_any        = gnt0 | gnt1;
    assign bus.m0_wr_gnt = gnt0;
    assign bus.m1_wr_gnt = gnt1;

    // Steer the winning writer's address/data toward the registered issue stage.
    always_comb begin
        sel_addr = bus.m0_wr_addr;
        sel_data = bus.m0_wr_data;
        if (gnt1) begin
            sel_addr = bus.m1_wr_addr;
            sel_data = bus.m1_wr_data;
        end
    end

    assign sel_in_range = ({1'b0, sel_addr} < DEPTH_LIM);

    // Remember the last winner; after reset m0 is favoured on the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_wr <= 1'b1;
        end else if (gnt0) begin
            last_wr <= 1'b0;
        end else if (gnt1) begin
            last_wr <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered write issue and out-of-range tracking
    // ------------------------------------------------------------------
    logic          wren_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic          oob_q;

    // Issue the granted write one cycle later; out-of-range writes are accepted but never reach the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wren_q <= wr_any & sel_in_range;
            if (wr_any) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
        end
    end

    // Sticky flag for any dropped out-of-range write; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            oob_q <= 1'b0;
        end else if (wr_any && !sel_in_range) begin
            oob_q <= 1'b1;
        end
    end

    assign bus.ram_wren      = wren_q;
    assign bus.ram_wraddress = waddr_q;
    assign bus.ram_data      = wdata_q;
    assign bus.wr_oob_err    = oob_q;

    // ------------------------------------------------------------------
    // Read port: VGA first, CPU gets leftover cycles
    // ------------------------------------------------------------------
    logic              rd_gnt;
    logic [RD_LAT-1:0] rd_pipe;     // one bit per CPU read in flight inside the RAM
    logic              rd_vld_q;
    logic [QW-1:0]     rd_dat_q;

    // Unregistered mux so VGA sees the bare RAM latency.
    assign bus.ram_rdaddress = bus.vga_rd_en ? bus.vga_rd_addr : bus.cpu_rd_addr;
    assign rd_gnt            = bus.cpu_rd_req & ~bus.vga_rd_en & ~reset;
    assign bus.cpu_rd_gnt    = rd_gnt;

    // Track CPU reads through the RAM latency; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // Capture ram_q when the tracked read lands and pulse valid the following cycle; data holds until the next return.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= rd_pipe[RD_LAT-1];
            if (rd_pipe[RD_LAT-1]) begin
                rd_dat_q <= bus.ram_q;
            end
        end
    end

    assign bus.cpu_rd_valid = rd_vld_q;
    assign bus.cpu_rd_data  = rd_dat_q;

`ifdef PIXMEM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Stall counters
    // ------------------------------------------------------------------
    logic m0_stall;
    logic m1_stall;
    logic rd_stall;

    assign m0_stall = bus.m0_wr_req  & ~gnt0;
    assign m1_stall = bus.m1_wr_req  & ~gnt1;
    assign rd_stall = bus.cpu_rd_req & ~rd_gnt;

    // Count waiting cycles per requester, saturating at all-ones; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            m0_stall_cnt     <= '0;
            m1_stall_cnt     <= '0;
            cpu_rd_stall_cnt <= '0;
        end else begin
            if (m0_stall && (m0_stall_cnt != 16'hFFFF)) begin
                m0_stall_cnt <= m0_stall_cnt + 16'd1;
            end
            if (m1_stall && (m1_stall_cnt != 16'hFFFF)) begin
                m1_stall_cnt <= m1_stall_cnt + 16'd1;
            end
            if (rd_stall && (cpu_rd_stall_cnt != 16'hFFFF)) begin
                cpu_rd_stall_cnt <= cpu_rd_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Bench for pixel_mem_arbiter: directed scenarios followed by a randomized mixed-traffic phase.
// A behavioural RAM sits on the RAM ports; a transaction-level model predicts grants, write issue and read returns.
// Inputs change 1 ns after the rising edge, outputs are compared 3 ns after it.
module tb_pixel_mem_arbiter;

    localparam int AW     = 18;
    localparam int DW     = 32;
    localparam int QW     = 8;
    localparam int DEPTH  = 240000;
    localparam int RD_LAT = 2;
    localparam int MEMSZ  = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_mem_arbiter_if #(.AW(AW), .DW(DW), .QW(QW)) bus ();

`ifdef PIXMEM_ARB_PERF_EN
    logic        perf_clr;
    logic [15:0] m0_sc;
    logic [15:0] m1_sc;
    logic [15:0] rd_sc;
    pixel_mem_arbiter #(.AW(AW), .DW(DW), .QW(QW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(rst), .perf_clr(perf_clr),
        .m0_stall_cnt(m0_sc), .m1_stall_cnt(m1_sc), .cpu_rd_stall_cnt(rd_sc), .bus(bus));
`else
    pixel_mem_arbiter #(.AW(AW), .DW(DW), .QW(QW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(rst), .bus(bus));
`endif

    // Behavioural RAM: writes land on the edge ending a ram_wren cycle; reads return two cycles after the address.
    logic [DW-1:0] ram_mem [0:MEMSZ-1];
    logic [AW-1:0] ram_ra_q;
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_wraddress] <= bus.ram_data;
        ram_ra_q  <= bus.ram_rdaddress;
        bus.ram_q <= ram_mem[ram_ra_q][QW-1:0];
    end

    // Reference model state
    typedef struct {
        int            due;
        logic [QW-1:0] dat;
    } rd_t;

    logic [DW-1:0] shadow [0:MEMSZ-1];   // memory contents as the model believes them
    rd_t           rdq[$];               // CPU reads expected back, in order
    logic          m_last;
    logic          m_wren;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_zero;               // previous cycle was in reset
    logic          m_oob;
    logic [QW-1:0] m_rdata;
    int            cyc;
    int            checks;
    int            errors;
    int            n_wr;
    int            n_rd;
    logic          g0_seen;
    logic          g1_seen;
    logic          rg_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check every output against the model, then advance the model.
    task automatic step();
        logic          e_g0;
        logic          e_g1;
        logic          e_rg;
        logic          e_vld;
        logic [AW-1:0] e_ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        #2;
        e_g0 = !rst && bus.m0_wr_req && (!bus.m1_wr_req || m_last);
        e_g1 = !rst && bus.m1_wr_req && !e_g0;
        e_rg = !rst && bus.cpu_rd_req && !bus.vga_rd_en;
        e_ra = bus.vga_rd_en ? bus.vga_rd_addr : bus.cpu_rd_addr;
        chk("m0_wr_gnt", 64'(bus.m0_wr_gnt), 64'(e_g0));
        chk("m1_wr_gnt", 64'(bus.m1_wr_gnt), 64'(e_g1));
        chk("cpu_rd_gnt", 64'(bus.cpu_rd_gnt), 64'(e_rg));
        chk("ram_rdaddress", 64'(bus.ram_rdaddress), 64'(e_ra));
        chk("ram_wren", 64'(bus.ram_wren), 64'(m_wren));
        if (m_wren || m_zero) begin
            chk("ram_wraddress", 64'(bus.ram_wraddress), 64'(m_waddr));
            chk("ram_data", 64'(bus.ram_data), 64'(m_wdata));
        end
        chk("wr_oob_err", 64'(bus.wr_oob_err), 64'(m_oob));
        e_vld = (rdq.size() > 0) && (rdq[0].due == cyc);
        chk("cpu_rd_valid", 64'(bus.cpu_rd_valid), 64'(e_vld));
        if (e_vld) begin
            m_rdata = rdq[0].dat;
            void'(rdq.pop_front());
            n_rd++;
        end
        chk("cpu_rd_data", 64'(bus.cpu_rd_data), 64'(m_rdata));
        g0_seen = bus.m0_wr_gnt;
        g1_seen = bus.m1_wr_gnt;
        rg_seen = bus.cpu_rd_gnt;

        m_zero = rst;
        if (rst) begin
            m_wren  = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_oob   = 1'b0;
            m_last  = 1'b1;
            m_rdata = '0;
            rdq.delete();
        end else begin
            if (e_rg) rdq.push_back('{cyc + RD_LAT + 1, shadow[e_ra][QW-1:0]});
            if (e_g0 || e_g1) begin
                wa      = e_g0 ? bus.m0_wr_addr : bus.m1_wr_addr;
                wd      = e_g0 ? bus.m0_wr_data : bus.m1_wr_data;
                m_last  = e_g1;
                m_waddr = wa;
                m_wdata = wd;
                if (int'(wa) < DEPTH) begin
                    m_wren     = 1'b1;
                    shadow[wa] = wd;
                    n_wr++;
                end else begin
                    m_wren = 1'b0;
                    m_oob  = 1'b1;
                end
            end else begin
                m_wren = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single write through one writer, holding the request until it is granted.
    task automatic wr(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        logic got;
        n = 0;
        if (who == 0) begin
            bus.m0_wr_req = 1'b1; bus.m0_wr_addr = a; bus.m0_wr_data = d;
        end else begin
            bus.m1_wr_req = 1'b1; bus.m1_wr_addr = a; bus.m1_wr_data = d;
        end
        step();
        got = (who == 0) ? g0_seen : g1_seen;
        while (!got && n < 8) begin
            step();
            got = (who == 0) ? g0_seen : g1_seen;
            n++;
        end
        chk("wr_gnt_wait", 64'(got), 64'(1));
        bus.m0_wr_req = 1'b0;
        bus.m1_wr_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic pend0, pend1, pendr;
        int   wr_before;
        checks = 0; errors = 0; cyc = 0; n_wr = 0; n_rd = 0;
        for (int i = 0; i < MEMSZ; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
`ifdef PIXMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        rst = 1'b1;
        bus.m0_wr_req = 1'b0; bus.m0_wr_addr = '0; bus.m0_wr_data = '0;
        bus.m1_wr_req = 1'b0; bus.m1_wr_addr = '0; bus.m1_wr_data = '0;
        bus.vga_rd_en = 1'b0; bus.vga_rd_addr = '0;
        bus.cpu_rd_req = 1'b0; bus.cpu_rd_addr = '0;
        m_last = 1'b1; m_wren = 1'b0; m_waddr = '0; m_wdata = '0;
        m_zero = 1'b1; m_oob = 1'b0; m_rdata = '0;
        @(posedge clk);
        #1;
        cyc = 1;

        // Reset holds everything quiet, even with requests pending.
        bus.m0_wr_req = 1'b1; bus.cpu_rd_req = 1'b1;
        idle(2);
        bus.m0_wr_req = 1'b0; bus.cpu_rd_req = 1'b0;
        rst = 1'b0;
        idle(1);

        // m0 alone: grant now, RAM write next cycle, nothing after.
        wr(0, 18'h00010, 32'hDEADBEEF);
        idle(2);

        // Both writers saturating right after reset: strict m0/m1 alternation.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus.m0_wr_req = 1'b1; bus.m0_wr_addr = 18'h00040; bus.m0_wr_data = 32'hA0A0_0000;
        bus.m1_wr_req = 1'b1; bus.m1_wr_addr = 18'h00080; bus.m1_wr_data = 32'hB0B0_0000;
        wr_before = n_wr;
        for (int i = 0; i < 4; i++) begin
            step();
            if (g0_seen) begin
                bus.m0_wr_addr = bus.m0_wr_addr + 18'd1;
                bus.m0_wr_data = bus.m0_wr_data + 32'd1;
            end
            if (g1_seen) begin
                bus.m1_wr_addr = bus.m1_wr_addr + 18'd1;
                bus.m1_wr_data = bus.m1_wr_data + 32'd1;
            end
        end
        bus.m0_wr_req = 1'b0; bus.m1_wr_req = 1'b0;
        idle(2);
        chk("alt_wr_count", 64'(n_wr - wr_before), 64'(4));

        // Preload read targets.
        wr(0, 18'h00100, 32'h0000005A);
        for (int i = 0; i < 4; i++) wr(1, AW'(i), DW'(32'h11 * (i + 1)));
        for (int i = 0; i < 16; i++) wr(i % 2, AW'(32'h200 + i), $urandom);
        idle(3);

        // VGA owns the read port for 3 cycles; CPU waits, then gets 0x5A.
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 18'h00100;
        bus.vga_rd_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.vga_rd_addr = AW'(32'h300 + i);
            step();
        end
        bus.vga_rd_en = 1'b0;
        step();
        chk("cpu_gnt_after_vga", 64'(rg_seen), 64'(1));
        bus.cpu_rd_req = 1'b0;
        idle(4);
        chk("cpu_rd_data_5a", 64'(bus.cpu_rd_data), 64'(8'h5A));

        // Four back-to-back CPU reads return in order.
        for (int i = 0; i < 4; i++) begin
            bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = AW'(i);
            step();
        end
        bus.cpu_rd_req = 1'b0;
        idle(5);

        // Read granted two cycles after the write's grant sees the new data.
        wr(0, 18'h00020, 32'h000000A7);
        idle(1);
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 18'h00020;
        step();
        bus.cpu_rd_req = 1'b0;
        idle(4);
        chk("hazard_new_data", 64'(bus.cpu_rd_data), 64'(8'hA7));

        // Randomized traffic: writes into 0x1000.., CPU reads from the preloaded 0x200 block, random VGA.
        pend0 = 1'b0; pend1 = 1'b0; pendr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend0 && ($urandom_range(0, 2) == 0)) begin
                pend0 = 1'b1; bus.m0_wr_req = 1'b1;
                bus.m0_wr_addr = AW'(32'h1000 + $urandom_range(0, 255));
                bus.m0_wr_data = $urandom;
            end
            if (!pend1 && ($urandom_range(0, 2) == 0)) begin
                pend1 = 1'b1; bus.m1_wr_req = 1'b1;
                bus.m1_wr_addr = AW'(32'h1000 + $urandom_range(0, 255));
                bus.m1_wr_data = $urandom;
            end
            if (!pendr && ($urandom_range(0, 1) == 0)) begin
                pendr = 1'b1; bus.cpu_rd_req = 1'b1;
                bus.cpu_rd_addr = AW'(32'h200 + $urandom_range(0, 15));
            end
            bus.vga_rd_en   = ($urandom_range(0, 2) == 0);
            bus.vga_rd_addr = AW'($urandom_range(0, MEMSZ - 1));
            step();
            if (g0_seen) begin pend0 = 1'b0; bus.m0_wr_req = 1'b0; end
            if (g1_seen) begin pend1 = 1'b0; bus.m1_wr_req = 1'b0; end
            if (rg_seen) begin pendr = 1'b0; bus.cpu_rd_req = 1'b0; end
        end
        bus.m0_wr_req = 1'b0; bus.m1_wr_req = 1'b0;
        bus.cpu_rd_req = 1'b0; bus.vga_rd_en = 1'b0;
        idle(5);
        chk("rdq_drained", 64'(rdq.size()), 64'(0));

        // Range boundary: last valid address is written, DEPTH and 0x3FFFF are dropped and flagged.
        wr(1, AW'(DEPTH - 1), 32'h0000_00C3);
        idle(2);
        chk("oob_clear_in_range", 64'(bus.wr_oob_err), 64'(0));
        wr(1, 18'h3FFFF, 32'h1234_5678);
        idle(3);
        chk("oob_sticky", 64'(bus.wr_oob_err), 64'(1));
        wr(0, AW'(DEPTH), 32'h0BAD_0BAD);
        idle(2);

        // CPU read granted, reset the next cycle: the return is discarded.
        bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 18'h00001;
        step();
        bus.cpu_rd_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(6);
        chk("oob_cleared_by_reset", 64'(bus.wr_oob_err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_mem_arbiter.md
Name: pixel_mem_arbiter

Overview:
Owns both ports of the pixel frame RAM and decides who uses them each cycle.
- Write port: shared round-robin between two writers (m0: processor store path, m1: image loader).
- Read port: given to the VGA scan-out whenever it fetches; otherwise lent to a processor read-back requester.
- Sits between the VGA controller / processor and the RAM instance at the top level.

Parameters:
AW, 18, address width of both RAM ports
DW, 32, RAM write data width
QW, 8, RAM read data width
DEPTH, 262144, number of valid addresses; writes at or above this are dropped
RD_LAT, 2, RAM read latency in cycles from address presented to ram_q valid

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_wr_req  in  1  writer 0 request; held until granted
m0_wr_addr  in  AW  writer 0 address
m0_wr_data  in  DW  writer 0 data
m0_wr_gnt  out  1  writer 0 accepted this cycle
m1_wr_req  in  1  writer 1 request
m1_wr_addr  in  AW  writer 1 address
m1_wr_data  in  DW  writer 1 data
m1_wr_gnt  out  1  writer 1 accepted this cycle
vga_rd_en  in  1  VGA fetching this cycle (absolute priority)
vga_rd_addr  in  AW  VGA read address
cpu_rd_req  in  1  processor read request; held until granted
cpu_rd_addr  in  AW  processor read address
cpu_rd_gnt  out  1  processor read accepted this cycle
cpu_rd_valid  out  1  one-cycle pulse, read data valid
cpu_rd_data  out  QW  processor read data, held until next valid
wr_oob_err  out  1  sticky: a write to addr >= DEPTH was dropped
ram_wren  out  1  RAM write enable
ram_wraddress  out  AW  RAM write address
ram_data  out  DW  RAM write data
ram_rdaddress  out  AW  RAM read address
ram_q  in  QW  RAM read data

Behaviour:
- Reset: every registered output is 0 (ram_wren, ram_wraddress, ram_data, cpu_rd_valid, cpu_rd_data, wr_oob_err). The read-valid pipeline is cleared. The RR pointer last_wr is set to 1, so m0 wins the first conflict.
- Write grant is combinational:
  - Only one requester: that requester is granted.
  - Both requesting: grant m0 if last_wr==1, else m1.
  - last_wr updates to the granted index only on a grant.
  - At most one m*_wr_gnt per cycle. No grant while reset is high.
- Write issue is registered. When granted in cycle N, ram_wren/ram_wraddress/ram_data carry that transaction in cycle N+1. ram_wren is 0 in any cycle after a no-grant cycle.
- Out-of-bounds write (addr >= DEPTH):
  - Still granted, so the requester is not stalled.
  - ram_wren stays 0 in N+1.
  - wr_oob_err is set in N+1 and stays set until reset.
- Write throughput: one write per cycle sustained. Both writers continuously requesting alternate m0, m1, m0, ...
- Read mux is combinational, so VGA sees zero added latency:
  - ram_rdaddress = vga_rd_addr when vga_rd_en, else cpu_rd_addr.
  - cpu_rd_gnt = cpu_rd_req & ~vga_rd_en & ~reset.
- Read return: valid shift register of length RD_LAT. For a grant in cycle G:
  - ram_q is captured into cpu_rd_data at the end of cycle G+RD_LAT.
  - cpu_rd_valid pulses in cycle G+RD_LAT+1.
  - Back-to-back grants are pipelined, one return per cycle, in order.
- VGA read data comes straight from ram_q and is not registered here.
- Reset mid-flight: outstanding reads are discarded and no cpu_rd_valid follows. A write granted in the same cycle reset asserts is not issued.
- Hazard: a read granted at least 2 cycles after the write's grant cycle returns the new data. Closer spacing returns whatever the RAM returns; no forwarding is done.
- Simultaneous read and write in the same cycle are independent and both proceed.

Optional Feature:
Macro PIXMEM_ARB_PERF_EN.
- Defined: adds input perf_clr (1) and outputs m0_stall_cnt, m1_stall_cnt, cpu_rd_stall_cnt (16 each).
  - Each counter increments in every cycle its requester has req=1 and gnt=0.
  - Counters saturate at 16'hFFFF.
  - Cleared by reset or perf_clr; perf_clr wins over increment.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- m0 only, addr 0x00010, data 0xDEADBEEF, 1 cycle -> m0_wr_gnt=1 in cycle N; ram_wren=1, ram_wraddress=0x00010, ram_data=0xDEADBEEF in N+1; ram_wren=0 in N+2.
- m0 and m1 both held high for 4 cycles after reset -> grants m0, m1, m0, m1; four consecutive ram_wren cycles with matching addr/data.
- vga_rd_en=1 for 3 cycles while cpu_rd_req=1 at addr 0x00100 (RAM holds 0x5A) -> cpu_rd_gnt=0 for those 3 cycles, ram_rdaddress follows VGA; cpu_rd_gnt=1 in cycle 4; cpu_rd_valid pulse with cpu_rd_data=0x5A 3 cycles later.
- 4 back-to-back CPU reads at addresses 0..3 with vga_rd_en=0 -> 4 consecutive cpu_rd_valid cycles, data in address order.
- m1 writes addr 0x3FFFF with DEPTH=240000 -> m1_wr_gnt=1, ram_wren stays 0, wr_oob_err=1 until reset.
- CPU read granted, then reset asserted the next cycle -> no cpu_rd_valid afterwards; all outputs 0 during and after reset.
